// File: rtl/sift_desc_pkg.sv
// Shared definitions for the SIFT descriptor sample path: window geometry,
// sweeper state encoding and the per-sample record that the sweeper and the
// histogram stage exchange.
package sift_desc_pkg;

   localparam int WIN_SIZE = 16;
   localparam int WIN_HALF = 8;
   localparam int SUB_SIZE = 4;
   localparam int COORD_W  = 5;
   localparam int BIN_W    = 2;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

   typedef struct packed {
      logic [7:0]               addr;
      logic signed [COORD_W-1:0] x;
      logic signed [COORD_W-1:0] y;
      logic                     inwin;
      logic [2*BIN_W-1:0]       bin;
      logic                     last;
   } sample_t;

endpackage

// File: rtl/desc_bin_map.sv
// Maps a rotated (x, y) offset to its 4x4 descriptor sub-region.
// Ports:
//   x, y   in   signed rotated offsets
//   inwin  out  both offsets inside [-WIN_HALF, WIN_HALF-1]
//   bin    out  {by, bx}; forced to 0 when the sample is outside the window
module desc_bin_map #(
   parameter int COORD_W = sift_desc_pkg::COORD_W
) (
   input  logic [COORD_W-1:0]              x,
   input  logic [COORD_W-1:0]              y,
   output logic                            inwin,
   output logic [2*sift_desc_pkg::BIN_W-1:0] bin
);
   import sift_desc_pkg::*;

   // Offsets are shifted into 0..15 so the sub-region is a plain divide by 4.
   logic signed [5:0] xs;
   logic signed [5:0] ys;
   logic [BIN_W-1:0]  bx;
   logic [BIN_W-1:0]  by;
   logic              x_ok;
   logic              y_ok;

   assign xs = 6'($signed(x)) + 6'(WIN_HALF);
   assign ys = 6'($signed(y)) + 6'(WIN_HALF);

   assign x_ok = (xs >= 6'sd0) && (xs <= 6'(2*WIN_HALF-1));
   assign y_ok = (ys >= 6'sd0) && (ys <= 6'(2*WIN_HALF-1));

   assign bx = BIN_W'(xs >>> $clog2(SUB_SIZE));
   assign by = BIN_W'(ys >>> $clog2(SUB_SIZE));

   assign inwin = x_ok && y_ok;
   assign bin   = inwin ? {by, bx} : '0;

endmodule

// File: rtl/rot_sample_sweeper.sv
// Sweeps the 16x16 sample window through the external direction-ROM pair for
// one keypoint and streams the registered rotated offsets, window flag and
// sub-region index downstream over valid/ready.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   start, orient        sweep request and orientation (accepted in IDLE only)
//   rom_sel, rom_addr    ROM bank select and sample address {row, col}
//   rom_x, rom_y         combinational ROM data for rom_addr
//   out_valid/out_ready  output handshake
//   out_addr/x/y/inwin/bin/last  registered sample
//   busy, done           sweep in progress, one-cycle completion pulse
//
// state | meaning
// IDLE  | waiting for start
// RUN   | walking addresses 0..255 into the output register
// DRAIN | last sample held until downstream accepts it
module rot_sample_sweeper #(
   parameter int COORD_W = sift_desc_pkg::COORD_W,
   parameter int ORI_W   = 6
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [ORI_W-1:0]   orient,
   output logic [ORI_W-1:0]   rom_sel,
   output logic [7:0]         rom_addr,
   input  logic [COORD_W-1:0] rom_x,
   input  logic [COORD_W-1:0] rom_y,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [7:0]         out_addr,
   output logic [COORD_W-1:0] out_x,
   output logic [COORD_W-1:0] out_y,
   output logic               out_inwin,
   output logic [3:0]         out_bin,
   output logic               out_last,
   output logic               busy,
   output logic               done
);
   import sift_desc_pkg::*;

   localparam logic [7:0] LAST_ADDR = 8'(WIN_SIZE*WIN_SIZE-1);

   state_t     state;
   logic [7:0] cnt;
   logic       map_inwin;
   logic [3:0] map_bin;
   logic       load;

   desc_bin_map #(.COORD_W(COORD_W)) u_bin_map (
      .x     (rom_x),
      .y     (rom_y),
      .inwin (map_inwin),
      .bin   (map_bin)
   );

   // The output register is free whenever it is empty or being drained.
   assign load     = !out_valid || out_ready;
   assign rom_addr = cnt;
   assign busy     = (state != IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         rom_sel   <= '0;
         out_valid <= 1'b0;
         out_addr  <= '0;
         out_x     <= '0;
         out_y     <= '0;
         out_inwin <= 1'b0;
         out_bin   <= '0;
         out_last  <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (state)
            IDLE: begin
               if (start) begin
                  rom_sel <= orient;
                  cnt     <= '0;
                  state   <= RUN;
               end
            end
            RUN: begin
               if (load) begin
                  out_valid <= 1'b1;
                  out_addr  <= cnt;
                  out_x     <= rom_x;
                  out_y     <= rom_y;
                  out_inwin <= map_inwin;
                  out_bin   <= map_bin;
                  out_last  <= (cnt == LAST_ADDR);
                  // Counter wraps to 0 after the last address; it is idle in DRAIN.
                  cnt       <= cnt + 8'd1;
                  if (cnt == LAST_ADDR) state <= DRAIN;
               end
            end
            DRAIN: begin
               if (out_valid && out_ready) begin
                  out_valid <= 1'b0;
                  done      <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_rot_sample_sweeper.sv
module tb_rot_sample_sweeper;

   typedef struct {
      int addr;
      int x;
      int y;
      int inwin;
      int bin;
      int last;
      int sel;
   } exp_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       start = 1'b0;
   logic [5:0] orient = '0;
   logic [5:0] rom_sel;
   logic [7:0] rom_addr;
   logic [4:0] rom_x;
   logic [4:0] rom_y;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] out_addr;
   logic [4:0] out_x;
   logic [4:0] out_y;
   logic       out_inwin;
   logic [3:0] out_bin;
   logic       out_last;
   logic       busy;
   logic       done;

   logic [4:0] tx [256];
   logic [4:0] ty [256];
   exp_t       q [$];
   int         n_cmp = 0;
   int         n_bad = 0;
   int         rdy_pct = 100;
   bit         stall_last = 1'b0;
   int         tbl_mode = 0;

   rot_sample_sweeper #(.COORD_W(5), .ORI_W(6)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .orient    (orient),
      .rom_sel   (rom_sel),
      .rom_addr  (rom_addr),
      .rom_x     (rom_x),
      .rom_y     (rom_y),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_addr  (out_addr),
      .out_x     (out_x),
      .out_y     (out_y),
      .out_inwin (out_inwin),
      .out_bin   (out_bin),
      .out_last  (out_last),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   assign rom_x = tx[rom_addr];
   assign rom_y = ty[rom_addr];

   function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endfunction

   task automatic set_geom();
      for (int a = 0; a < 256; a++) begin
         tx[a] = 5'((a % 16) - 8);
         ty[a] = 5'((a / 16) - 8);
      end
   endtask

   task automatic set_random();
      for (int a = 0; a < 256; a++) begin
         tx[a] = 5'($urandom_range(0, 31));
         ty[a] = 5'($urandom_range(0, 31));
      end
      tx[5] = 5'h18; ty[5] = 5'h07;
      tx[6] = 5'h08; ty[6] = 5'h00;
      tx[7] = 5'h00; ty[7] = 5'h17;
   endtask

   // Reference: window test and 4x4 sub-region from plain integer arithmetic.
   task automatic push_sweep(input logic [5:0] ori);
      exp_t e;
      for (int a = 0; a < 256; a++) begin
         e.addr  = a;
         e.x     = int'($signed(tx[a]));
         e.y     = int'($signed(ty[a]));
         e.inwin = (e.x >= -8 && e.x <= 7 && e.y >= -8 && e.y <= 7) ? 1 : 0;
         e.bin   = e.inwin ? (((e.y + 8) / 4) * 4 + (e.x + 8) / 4) : 0;
         e.last  = (a == 255) ? 1 : 0;
         e.sel   = int'(ori);
         q.push_back(e);
      end
   endtask

   // Downstream ready: random with a given acceptance rate, or a forced
   // five-cycle stall on the last beat.
   initial begin
      int hold = 0;
      forever begin
         @(posedge clk);
         #1;
         if (hold > 0) begin
            out_ready = 1'b0;
            hold--;
         end else if (stall_last && out_valid && out_last) begin
            out_ready  = 1'b0;
            hold       = 4;
            stall_last = 1'b0;
         end else begin
            out_ready = ($urandom_range(0, 99) < rdy_pct);
         end
      end
   end

   // Monitor / scoreboard.
   logic [39:0] cur_snap;
   assign cur_snap = {out_valid, out_addr, out_x, out_y, out_inwin, out_bin, out_last,
                      rom_addr, busy, rom_sel};

   initial begin
      bit          prev_rst = 1'b0;
      bit          prev_stall = 1'b0;
      bit          exp_done = 1'b0;
      logic [39:0] snap = '0;
      exp_t        e;
      logic [29:0] ev;
      logic [29:0] av;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_rst   = 1'b1;
            prev_stall = 1'b0;
            exp_done   = 1'b0;
            continue;
         end
         if (prev_rst)
            chk("reset_state", 64'({out_valid, busy, done, rom_addr, rom_sel, out_addr, out_x,
                                    out_y, out_inwin, out_bin, out_last}), 64'(0));
         prev_rst = 1'b0;
         chk("done_pulse", 64'(done), 64'(exp_done));
         if (prev_stall) chk("stall_hold", 64'(cur_snap), 64'(snap));
         exp_done = 1'b0;
         if (out_valid && out_ready) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_bad++;
               $display("FAIL extra_beat: got addr %0d expected no beat", out_addr);
            end else begin
               e  = q.pop_front();
               ev = {8'(e.addr), 5'(e.x), 5'(e.y), 1'(e.inwin), 4'(e.bin), 1'(e.last), 6'(e.sel)};
               av = {out_addr, out_x, out_y, out_inwin, out_bin, out_last, rom_sel};
               n_cmp++;
               if (av !== ev) begin
                  n_bad++;
                  $display("FAIL beat: got addr=%0d x=%0d y=%0d inwin=%0d bin=%0h last=%0d sel=%0h expected addr=%0d x=%0d y=%0d inwin=%0d bin=%0h last=%0d sel=%0h",
                           out_addr, $signed(out_x), $signed(out_y), out_inwin, out_bin, out_last, rom_sel,
                           e.addr, e.x, e.y, e.inwin, e.bin, e.last, e.sel);
               end
               exp_done = (e.last == 1);
            end
            if (tbl_mode == 1 && out_addr == 8'd5)
               chk("edge_xm8_y7", 64'({out_inwin, out_bin}), 64'(5'b1_1100));
            if (tbl_mode == 1 && out_addr == 8'd6)
               chk("edge_xp8", 64'({out_inwin, out_bin}), 64'(0));
            if (tbl_mode == 1 && out_addr == 8'd7)
               chk("edge_ym9", 64'(out_inwin), 64'(0));
            if (tbl_mode == 0 && out_addr == 8'h96)
               chk("bin_96", 64'({out_inwin, out_bin}), 64'(5'b1_1001));
         end
         prev_stall = out_valid && !out_ready;
         snap       = cur_snap;
      end
   end

   task automatic do_sweep(input logic [5:0] ori, input int busy_at, input int rst_at,
                           input bit timing);
      int first_v = -1;
      int done_c  = -1;
      bit hit_rst = 1'b0;
      push_sweep(ori);
      start  = 1'b1;
      orient = ori;
      @(posedge clk);
      #1;
      start  = 1'b0;
      orient = 6'($urandom);
      for (int cyc = 1; cyc <= 4000; cyc++) begin
         start = (cyc == busy_at);
         if (cyc == busy_at) orient = ~ori;
         if (cyc == rst_at) begin
            rst     = 1'b1;
            start   = 1'b1;
            hit_rst = 1'b1;
            q.delete();
         end
         @(negedge clk);
         if (timing && cyc == 1) chk("run_cycle1", 64'({busy, rom_addr}), 64'({1'b1, 8'h00}));
         if (first_v < 0 && out_valid) first_v = cyc;
         if (done) begin
            done_c = cyc;
            chk("idle_after_done", 64'(busy), 64'(0));
            break;
         end
         @(posedge clk);
         #1;
         if (hit_rst) begin
            rst   = 1'b0;
            start = 1'b0;
            break;
         end
      end
      if (!hit_rst) begin
         if (done_c < 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sweep_timeout: got no done expected done within 4000 cycles");
         end
         chk("queue_empty", 64'(q.size()), 64'(0));
         if (timing) begin
            chk("first_valid_cycle", 64'(first_v), 64'(2));
            chk("done_cycle", 64'(done_c), 64'(258));
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      set_geom();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(posedge clk);
      #1;

      tbl_mode = 0; rdy_pct = 100;
      do_sweep(6'h15, 0, 0, 1'b1);

      set_random(); tbl_mode = 1; rdy_pct = 30;
      do_sweep(6'($urandom), 0, 0, 1'b0);

      set_geom(); tbl_mode = 0; rdy_pct = 60;
      do_sweep(6'h2a, 50, 0, 1'b0);

      set_random(); tbl_mode = 1; rdy_pct = 70;
      do_sweep(6'h11, 0, 100, 1'b0);
      rdy_pct = 100;
      do_sweep(6'h3c, 0, 0, 1'b0);

      stall_last = 1'b1;
      do_sweep(6'h07, 0, 0, 1'b0);

      repeat (3) @(posedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/rot_sample_sweeper.md
# rot_sample_sweeper

Sequencer that drives the SIFT descriptor stage's direction-ROM pair, which holds the rotated x/y offsets. For each keypoint it sweeps all 256 positions of the 16x16 sample window and registers the two signed 5-bit rotated offsets the ROMs return. It maps each sample to its 4x4 descriptor sub-region and streams the results downstream over a valid/ready handshake. It sits between the keypoint-orientation stage (start/orientation) and the histogram accumulator.

## Interface
Parameters:
- COORD_W, 5, width of rotated offset (two's complement)
- ORI_W, 6, width of orientation index used as ROM bank select

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; synchronous, active-high
- start  in  1  begin sweep; sampled only in IDLE
- orient  in  ORI_W  orientation index, latched on accepted start
- rom_sel  out  ORI_W  latched orientation, selects ROM bank
- rom_addr  out  8  sample address {row[3:0], col[3:0]}
- rom_x  in  COORD_W  rotated x offset for rom_addr (combinational ROM)
- rom_y  in  COORD_W  rotated y offset for rom_addr (combinational ROM)
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts
- out_addr  out  8  window address of the sample
- out_x, out_y  out  COORD_W  registered rom_x / rom_y
- out_inwin  out  1  both offsets in [-8, 7]
- out_bin  out  4  sub-region {by[1:0], bx[1:0]}; 0 when !out_inwin
- out_last  out  1  sample is address 255
- busy  out  1  state != IDLE
- done  out  1  one-cycle pulse after final sample accepted

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE: start=1 latches orient into rom_sel, clears the address counter, and moves to RUN. start is ignored outside IDLE.
- RUN: rom_addr = counter. The output register loads when (!out_valid || out_ready). On load:
  - out_* take the current rom_x, rom_y and rom_addr.
  - The counter increments.
  - If the counter was 255, the state moves to DRAIN; the counter wraps to 0 and is unused.
- DRAIN: when out_valid && out_ready, clear out_valid, pulse done, and go to IDLE.
- Backpressure: while out_valid && !out_ready, the output register and counter hold, and rom_addr stays stable.
- Mapping: bx = (x+8)>>2 and by = (y+8)>>2, computed in 6-bit signed arithmetic, 2-bit result.
  - out_inwin = (-8 <= x <= 7) && (-8 <= y <= 7).
  - Out-of-window samples are still emitted, with out_inwin=0 and out_bin=0.
- rom_sel is held stable from start to done.

## Timing
- Reset values: state IDLE, out_valid 0, done 0, busy 0, rom_addr 0, rom_sel 0, all out_* 0.
- Cycle 0: start=1 in IDLE. Cycle 1: RUN, busy=1, rom_addr=0. Cycle 2: first out_valid, with out_addr=0.
- With out_ready held high: 1 sample/cycle over cycles 2..257; out_last is asserted in cycle 257; done=1 and busy=0 in cycle 258.
- A new start is accepted at the earliest in the done cycle (258).
- rst mid-sweep: the next cycle is IDLE with all outputs at reset values. No done pulse; the partial sweep is discarded.
- start coincident with rst: reset wins.
- out_ready low in the cycle after out_last: the stall holds in DRAIN indefinitely, with done deferred.

## Structure
- Package sift_desc_pkg holds:
  - constants WIN_SIZE=16, WIN_HALF=8, SUB_SIZE=4, COORD_W=5, BIN_W=2
  - state enum {IDLE, RUN, DRAIN}
  - the out-sample struct
- Sub-module desc_bin_map: combinational (x, y) -> (inwin, bin), reused by the histogram stage.
- The top is the FSM, address counter and output register. The ROMs are external.

## Test plan
- Full sweep, ready always 1, ROM model: x = col-8, y = row-8.
  - Expect 256 beats with out_addr 0..255 in order, every out_inwin=1.
  - addr 8'h96: bin 4'b1001.
  - out_last only on addr 255; done in cycle 258.
- Bin edges:
  - rom_x=5'h18 (-8), rom_y=5'h07 → inwin=1, bin=4'b1100.
  - rom_x=5'h08 (+8) → inwin=0, bin=0.
  - rom_y=5'h17 (-9) → inwin=0.
- Backpressure: random out_ready at 30%.
  - No beat lost or duplicated; out_* and rom_addr stable while stalled.
  - Exactly 256 accepted beats.
- start while busy, at cycle 50: ignored. rom_sel is unchanged and the sweep completes normally with one done.
- rst at cycle 100: next cycle out_valid=0 and busy=0, with no done. A fresh start then restarts at out_addr=0 with the new orient on rom_sel.
- Last-beat stall: out_ready=0 when out_last appears, held 5 cycles. State stays DRAIN and done stays 0; done pulses the cycle after acceptance.
